// File: rtl/jk_count_ctrl.sv
// jk_count_ctrl: drives the J/K inputs of a WIDTH-bit bank of JK flip-flops
// so the bank behaves as a loadable up/down counter. The counter runs from
// a start value to its terminal count: all-ones when counting up, zero when
// counting down. The bank has no clear of its own, so after every reset an
// INIT cycle forces it to zero.
//
// Control handshake: START is a level sampled only in IDLE. It is neither
// queued nor acknowledged, so a START seen in INIT, LOAD or RUN is dropped.
// BUSY is high in LOAD and RUN. DONE is a one-cycle registered pulse that
// follows the RUN->IDLE transition taken on terminal count.
// STATE is a debug view of the FSM: 0=INIT, 1=IDLE, 2=LOAD, 3=RUN.
module jk_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLEAR,
    input  logic             START,
    input  logic             UP,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       STATE
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_LOAD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] toggle;

    // Terminal count follows the latched direction.
    assign term = dir_q ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    // Toggle enables for one up or down step. Bit i toggles when all lower
    // bits are 1 (up) or all lower bits are 0 (down); bit 0 always toggles.
    always_comb begin
        toggle    = '0;
        toggle[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            toggle[i] = toggle[i-1] & (dir_q ? Q[i-1] : ~Q[i-1]);
        end
    end

    // State and control registers; CLEAR abandons any run immediately.
    always_ff @(posedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            state_q <= S_INIT;
            load_q  <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic and J/K excitation. J=K=0 (bank holds) unless a state
    // explicitly excites the bank. ABORT takes priority over terminal count.
    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        J       = '0;
        K       = '0;
        unique case (state_q)
            S_INIT: begin
                K       = {WIDTH{1'b1}};
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (START) begin
                    load_d  = D;
                    dir_d   = UP;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else begin
                    J       = load_q;
                    K       = ~load_q;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else if (Q == term) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    J = toggle;
                    K = toggle;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    assign BUSY  = (state_q == S_LOAD) || (state_q == S_RUN);
    assign DONE  = done_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Bench for jk_count_ctrl with a 4-bit JK flip-flop bank modelled in the bench.
module tb_jk_count_ctrl;
  localparam int W = 4;
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  logic         clk = 1'b0;
  logic         clear_n;
  logic         start, up, abort_r;
  logic [W-1:0] d, q, j, k;
  logic         busy, done;
  logic [1:0]   state;

  int n_vec  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  jk_count_ctrl #(.WIDTH(W)) dut (
    .CLK(clk), .CLEAR(clear_n), .START(start), .UP(up), .ABORT(abort_r),
    .D(d), .Q(q), .J(j), .K(k), .BUSY(busy), .DONE(done), .STATE(state)
  );

  // JK flip-flop bank: no reset of its own
  always_ff @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b01:   q[i] <= 1'b0;
        2'b10:   q[i] <= 1'b1;
        2'b11:   q[i] <= ~q[i];
        default: q[i] <= q[i];
      endcase
    end
  end

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run and check every Q step against the scoreboard queue, then wait
  // (bounded) for DONE and check the START->DONE latency. Returns with DONE high.
  task automatic run_count(input logic [W-1:0] dv, input logic upv, input logic poke_start);
    logic [W-1:0] v, term, e;
    int cyc, exp_cyc;
    term = upv ? {W{1'b1}} : {W{1'b0}};
    v = dv;
    exp_q.push_back(v);
    while (v != term) begin
      v = upv ? v + 1'b1 : v - 1'b1;
      exp_q.push_back(v);
    end
    exp_cyc = upv ? (15 - int'(dv)) + 2 : int'(dv) + 2;
    start = 1'b1; d = dv; up = upv;
    tick();
    cyc = 0;
    // START while busy must be ignored
    start = poke_start; d = ~dv; up = ~upv;
    n_vec++;
    if (busy !== 1'b1 || state !== ST_LOAD) begin
      n_fail++;
      $display("FAIL load_state: busy=%b state=%0d, want busy=1 state=%0d", busy, state, ST_LOAD);
    end
    while (exp_q.size() > 0) begin
      tick();
      cyc++;
      e = exp_q.pop_front();
      n_vec++;
      if (q !== e || done !== 1'b0) begin
        n_fail++;
        $display("FAIL count_step: q=%h done=%b, want q=%h done=0", q, done, e);
      end
    end
    start = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_vec++;
    if (done !== 1'b1 || cyc !== exp_cyc) begin
      n_fail++;
      $display("FAIL done_latency: done=%b cycles=%0d, want done=1 cycles=%0d", done, cyc, exp_cyc);
    end
    n_vec++;
    if (busy !== 1'b0 || state !== ST_IDLE || q !== term) begin
      n_fail++;
      $display("FAIL done_idle: busy=%b state=%0d q=%h, want busy=0 state=1 q=%h", busy, state, q, term);
    end
  endtask

  task automatic check_quiet(input string nm, input logic [W-1:0] eq);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== eq || state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL %s: done=%b busy=%b q=%h state=%0d, want done=0 busy=0 q=%h state=1",
               nm, done, busy, q, state, eq);
    end
  endtask

  task automatic test_reset();
    clear_n = 1'b0; start = 1'b1; up = 1'b0; abort_r = 1'b0; d = 4'h7;
    repeat (3) tick();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || state !== ST_INIT || k !== 4'hF || j !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_vals: busy=%b done=%b state=%0d j=%h k=%h, want 0 0 0 0 f",
               busy, done, state, j, k);
    end
    clear_n = 1'b1;
    tick();
    // START held high through INIT is ignored: state is IDLE, not LOAD
    start = 1'b0;
    check_quiet("init_clears", 4'h0);
    tick();
    check_quiet("idle_holds", 4'h0);
  endtask

  task automatic test_down_count();
    run_count(4'h3, 1'b0, 1'b1);
    tick();
    check_quiet("down_done_clr", 4'h0);
  endtask

  task automatic test_up_count();
    run_count(4'hD, 1'b1, 1'b0);
    tick();
    check_quiet("up_done_clr", 4'hF);
    repeat (2) tick();
    check_quiet("up_hold_f", 4'hF);
  endtask

  task automatic test_abort();
    start = 1'b1; d = 4'h9; up = 1'b0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_vec++;
    if (q !== 4'h6 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: q=%h busy=%b, want q=6 busy=1", q, busy);
    end
    abort_r = 1'b1;
    tick();
    abort_r = 1'b0;
    check_quiet("abort_idle", 4'h6);
    repeat (3) tick();
    check_quiet("abort_hold", 4'h6);
    // ABORT in IDLE has no effect; START and ABORT together: START wins
    abort_r = 1'b1;
    tick();
    check_quiet("abort_idle_noop", 4'h6);
    start = 1'b1; d = 4'h2; up = 1'b0;
    tick();
    start = 1'b0; abort_r = 1'b0;
    n_vec++;
    if (state !== ST_LOAD) begin
      n_fail++;
      $display("FAIL start_wins: state=%0d, want %0d", state, ST_LOAD);
    end
    // ABORT in LOAD: bank not loaded, back to IDLE
    abort_r = 1'b1;
    tick();
    abort_r = 1'b0;
    check_quiet("abort_load", 4'h6);
  endtask

  task automatic test_zero_start();
    run_count(4'h0, 1'b0, 1'b0);
    tick();
    check_quiet("zero_done_clr", 4'h0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] dv;
    dv = W'($urandom_range(1, 6));
    run_count(dv, 1'b0, 1'b0);
    // new run starts in the same IDLE cycle that DONE is high
    run_count(W'($urandom_range(8, 14)), 1'b1, 1'b1);
    tick();
    check_quiet("b2b_done_clr", 4'hF);
  endtask

  task automatic test_clear_mid_run();
    start = 1'b1; d = 4'h8; up = 1'b0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_vec++;
    if (q !== 4'h5) begin
      n_fail++;
      $display("FAIL clr_pre: q=%h, want 5", q);
    end
    clear_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || state !== ST_INIT) begin
      n_fail++;
      $display("FAIL clr_async: busy=%b done=%b state=%0d, want 0 0 0", busy, done, state);
    end
    tick();
    clear_n = 1'b1;
    tick();
    check_quiet("clr_init_q0", 4'h0);
    repeat (5) tick();
    check_quiet("clr_no_done", 4'h0);
  endtask

  initial begin
    test_reset();
    test_down_count();
    test_up_count();
    test_abort();
    test_zero_start();
    test_back_to_back();
    test_clear_mid_run();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard_left: %0d entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
